// File: rtl/beep_scheduler.sv
// Purpose : four-source prioritised beep pattern player driving a tone generator.
// Latency : request pulse -> pending next edge -> LOAD -> tone valid on first PLAY cycle.
// Backpr. : none; requests for an already-pending source are absorbed, stop aborts all.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   req[3:0]       one-cycle request pulses, bit 3 highest priority
//   stop           synchronous abort of the current pattern and all pending requests
//   tone_period    full tone period in clk cycles (0 = silence)
//   tone_en        high while a non-rest note plays
//   grant[3:0]     one-hot source currently owning the player (0 when idle)
//   busy           high in any state except IDLE
//   done           one-cycle pulse when a pattern's last step ends
//
// Optional feature: define BEEP_SCHEDULER_PREEMPT_EN to let a higher-priority
// pending request abort the running pattern at a tick boundary.
module beep_scheduler #(
    parameter int TICK_MAX  = 499_999,
    parameter int GAP_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        stop,
    output logic [17:0] tone_period,
    output logic        tone_en,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        done
);

    localparam logic [17:0] P_DO   = 18'd190840;
    localparam logic [17:0] P_RE   = 18'd170068;
    localparam logic [17:0] P_MI   = 18'd151515;
    localparam logic [17:0] P_FA   = 18'd143266;
    localparam logic [17:0] P_SO   = 18'd127551;
    localparam logic [17:0] P_LA   = 18'd113636;
    localparam logic [17:0] P_XI   = 18'd101214;
    localparam logic [17:0] P_REST = 18'd0;

    localparam logic [24:0] TICK_LAST = 25'(TICK_MAX);
    localparam logic [5:0]  GAP_LAST  = (GAP_TICKS > 0) ? 6'(GAP_TICKS - 1) : 6'd0;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t      r_state;
    logic [3:0]  r_pending;
    logic [2:0]  r_step;
    logic [24:0] r_tick_cnt;
    logic [5:0]  r_dur_cnt;     // ticks elapsed in the step, or in the gap
    logic [5:0]  r_dur;
    logic [17:0] r_tone_period;
    logic        r_tone_en;
    logic [3:0]  r_grant;
    logic        r_busy;
    logic        r_done;

    logic [3:0]  w_top;
    logic [3:0]  w_clr;
    logic [17:0] w_rom_period;
    logic [5:0]  w_rom_dur;
    logic        w_rom_last;
    logic        w_tick_end;
    logic        w_step_end;
    logic        w_gap_end;

    // Highest-priority pending source, one-hot.
    always_comb begin
        w_top = 4'b0000;
        if (r_pending[3])      w_top = 4'b1000;
        else if (r_pending[2]) w_top = 4'b0100;
        else if (r_pending[1]) w_top = 4'b0010;
        else if (r_pending[0]) w_top = 4'b0001;
    end

    // Pattern ROM indexed by the granted source and step index.
    always_comb begin
        w_rom_period = P_REST;
        w_rom_dur    = 6'd1;
        w_rom_last   = 1'b1;
        case (r_grant)
            4'b0001: begin
                w_rom_period = P_MI;
                w_rom_dur    = 6'd5;
            end
            4'b0010: begin
                w_rom_dur  = 6'd20;
                w_rom_last = (r_step == 3'd2);
                case (r_step)
                    3'd0:    w_rom_period = P_DO;
                    3'd1:    w_rom_period = P_MI;
                    default: w_rom_period = P_SO;
                endcase
            end
            4'b0100: begin
                w_rom_dur    = 6'd10;
                w_rom_last   = (r_step == 3'd3);
                w_rom_period = r_step[0] ? P_REST : P_LA;
            end
            4'b1000: begin
                w_rom_dur  = 6'd50;
                w_rom_last = (r_step == 3'd6);
                case (r_step)
                    3'd0:    w_rom_period = P_DO;
                    3'd1:    w_rom_period = P_RE;
                    3'd2:    w_rom_period = P_MI;
                    3'd3:    w_rom_period = P_FA;
                    3'd4:    w_rom_period = P_SO;
                    3'd5:    w_rom_period = P_LA;
                    default: w_rom_period = P_XI;
                endcase
            end
            default: ;
        endcase
    end

    assign w_tick_end = (r_tick_cnt == TICK_LAST);
    assign w_step_end = w_tick_end && (r_dur_cnt == r_dur - 6'd1);
    assign w_gap_end  = (GAP_TICKS == 0) || (w_tick_end && (r_dur_cnt == GAP_LAST));

`ifdef BEEP_SCHEDULER_PREEMPT_EN
    logic [3:0] w_higher;
    logic       w_preempt;
    // Bits strictly above the one-hot grant: ~(grant | grant-1).
    assign w_higher  = r_pending & ~(r_grant | (r_grant - 4'd1));
    assign w_preempt = (r_state == PLAY) && w_tick_end && (|w_higher);
`endif

    // Pending bit consumed by a grant this cycle; a coincident req re-sets it.
    always_comb begin
        w_clr = 4'b0000;
        if (r_state == IDLE) w_clr = w_top;
`ifdef BEEP_SCHEDULER_PREEMPT_EN
        if (w_preempt) w_clr = w_top;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pending     <= 4'b0000;
            r_step        <= 3'd0;
            r_tick_cnt    <= 25'd0;
            r_dur_cnt     <= 6'd0;
            r_dur         <= 6'd0;
            r_tone_period <= 18'd0;
            r_tone_en     <= 1'b0;
            r_grant       <= 4'b0000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else if (stop) begin
            // Abort wins over any req sampled in the same cycle.
            r_state       <= IDLE;
            r_pending     <= 4'b0000;
            r_step        <= 3'd0;
            r_tick_cnt    <= 25'd0;
            r_dur_cnt     <= 6'd0;
            r_tone_period <= 18'd0;
            r_tone_en     <= 1'b0;
            r_grant       <= 4'b0000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_pending <= (r_pending & ~w_clr) | req;
            case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_state <= LOAD;
                        r_grant <= w_top;
                        r_step  <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_tone_period <= w_rom_period;
                    r_tone_en     <= (w_rom_period != P_REST);
                    r_dur         <= w_rom_dur;
                    r_tick_cnt    <= 25'd0;
                    r_dur_cnt     <= 6'd0;
                    r_state       <= PLAY;
                end
                PLAY: begin
`ifdef BEEP_SCHEDULER_PREEMPT_EN
                    if (w_preempt) begin
                        r_grant <= w_top;
                        r_step  <= 3'd0;
                        r_state <= LOAD;
                    end else
`endif
                    if (w_step_end) begin
                        r_tick_cnt <= 25'd0;
                        r_dur_cnt  <= 6'd0;
                        if (!w_rom_last) begin
                            r_step  <= r_step + 3'd1;
                            r_state <= LOAD;
                        end else begin
                            r_done        <= 1'b1;
                            r_tone_period <= 18'd0;
                            r_tone_en     <= 1'b0;
                            r_state       <= GAP;
                        end
                    end else if (w_tick_end) begin
                        r_tick_cnt <= 25'd0;
                        r_dur_cnt  <= r_dur_cnt + 6'd1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 25'd1;
                    end
                end
                GAP: begin
                    if (w_gap_end) begin
                        r_state    <= IDLE;
                        r_grant    <= 4'b0000;
                        r_busy     <= 1'b0;
                        r_tick_cnt <= 25'd0;
                        r_dur_cnt  <= 6'd0;
                    end else if (w_tick_end) begin
                        r_tick_cnt <= 25'd0;
                        r_dur_cnt  <= r_dur_cnt + 6'd1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 25'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tone_period = r_tone_period;
    assign tone_en     = r_tone_en;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
